// File: rtl/lif_array_sched_if.sv
// Spike-event handshake bundle between the LIF scheduler and the routing fabric.
// Latency: n/a (wires only).
// Backpressure: master holds spk_valid/spk_id stable until the slave raises spk_ready.
//   spk_valid : event pending (master -> slave)
//   spk_id    : neuron index of the pending event (master -> slave)
//   spk_ready : consumer accepts the event on spk_valid && spk_ready (slave -> master)
interface lif_array_sched_if #(
    parameter int unsigned IDW = 3
) ();
    logic           spk_valid;
    logic [IDW-1:0] spk_id;
    logic           spk_ready;

    modport master (output spk_valid, output spk_id, input spk_ready);
    modport slave  (input spk_valid, input spk_id, output spk_ready);
endinterface

// File: rtl/lif_array_sched.sv
// Time-multiplexed LIF neuron array: one shared update datapath sweeps neurons 0..N-1 per start pulse.
// Latency: one neuron per enabled cycle; step_done pulses N+1 cycles after start when nothing stalls.
// Backpressure: a firing neuron waits (idx holds) while the spike register is full and not accepted.
//
// Ports:
//   clk, rst_n            : clock, asynchronous active-low reset
//   en_i                  : global enable; low freezes FSM, neuron state and the spike register
//   start_i               : begin a sweep (taken only in IDLE with en_i high)
//   cur_we_i/addr/data    : input-current array write port, usable at any time
//   rd_addr_i / rd_u_o    : debug read of U[rd_addr_i], registered, 1-cycle latency
//   busy_o / step_done_o  : sweep in progress / one-cycle pulse at sweep completion
//   spk (master)          : spike-ID event output with valid/ready handshake
// Build option: define LIF_SAT_EN to saturate both potential updates at 255 instead of wrapping.
module lif_array_sched #(
    parameter int unsigned N         = 8,
    parameter logic [7:0]  THRESHOLD = 8'd239,
    parameter logic [3:0]  REFRACT   = 4'd15,
    parameter int unsigned IDW       = $clog2(N)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               en_i,
    input  logic               start_i,
    input  logic               cur_we_i,
    input  logic [IDW-1:0]     cur_addr_i,
    input  logic [7:0]         cur_data_i,
    input  logic [IDW-1:0]     rd_addr_i,
    output logic [7:0]         rd_u_o,
    output logic               busy_o,
    output logic               step_done_o,
    lif_array_sched_if.master  spk
);

    typedef enum logic {
        ST_IDLE,
        ST_UPDATE
    } state_t;

    state_t         state_q, state_d;
    logic [IDW-1:0] idx_q, idx_d;
    logic           step_done_q, step_done_d;
    logic           spk_valid_q, spk_valid_d;
    logic [IDW-1:0] spk_id_q, spk_id_d;
    logic [7:0]     rd_u_q;

    logic [7:0]     u_q [N];
    logic [3:0]     t_q [N];
    logic [7:0]     i_q [N];

    // Neuron under evaluation
    logic [7:0]     cur_u, cur_i, u_fire, u_leak, u_new;
    logic [3:0]     cur_t, t_new;
    logic           fire, hs, stall, commit, idx_last;

    assign cur_u = u_q[idx_q];
    assign cur_t = t_q[idx_q];
    assign cur_i = i_q[idx_q];

    assign fire     = (cur_t == 4'd0) && (cur_u >= THRESHOLD);
    assign hs       = spk_valid_q && spk.spk_ready;
    // Only a firing neuron needs the spike register; non-firing ones always commit.
    assign stall    = fire && spk_valid_q && !spk.spk_ready;
    assign commit   = (state_q == ST_UPDATE) && !stall;
    assign idx_last = (idx_q == IDW'(N - 1));

`ifdef LIF_SAT_EN
    logic [8:0] fire_sum, leak_sum;
    // U >= THRESHOLD whenever this path is used, so the 9-bit difference never goes negative.
    assign fire_sum = {1'b0, cur_u} + {1'b0, cur_i} - {1'b0, THRESHOLD};
    assign leak_sum = {2'b00, cur_u[7:1]} + {1'b0, cur_i};
    assign u_fire   = fire_sum[8] ? 8'hFF : fire_sum[7:0];
    assign u_leak   = leak_sum[8] ? 8'hFF : leak_sum[7:0];
`else
    assign u_fire   = cur_u + cur_i - THRESHOLD;
    assign u_leak   = {1'b0, cur_u[7:1]} + cur_i;
`endif

    assign u_new = fire ? u_fire : u_leak;
    assign t_new = fire ? REFRACT : ((cur_t != 4'd0) ? cur_t - 4'd1 : 4'd0);

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        step_done_d = 1'b0;
        spk_valid_d = hs ? 1'b0 : spk_valid_q;
        spk_id_d    = spk_id_q;
        case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    state_d = ST_UPDATE;
                    idx_d   = '0;
                end
            end
            ST_UPDATE: begin
                if (commit) begin
                    if (fire) begin
                        // Overrides a same-cycle handshake clear so back-to-back events have no gap.
                        spk_valid_d = 1'b1;
                        spk_id_d    = idx_q;
                    end
                    if (idx_last) begin
                        state_d     = ST_IDLE;
                        step_done_d = 1'b1;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            idx_q       <= '0;
            step_done_q <= 1'b0;
            spk_valid_q <= 1'b0;
            spk_id_q    <= '0;
        end else if (en_i) begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            step_done_q <= step_done_d;
            spk_valid_q <= spk_valid_d;
            spk_id_q    <= spk_id_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < N; k++) begin
                u_q[k] <= '0;
                t_q[k] <= '0;
            end
        end else if (en_i && commit) begin
            u_q[idx_q] <= u_new;
            t_q[idx_q] <= t_new;
        end
    end

    // Current writes ignore en_i; a write landing on the neuron being evaluated
    // is seen only by the next sweep because the update above reads the old value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < N; k++) begin
                i_q[k] <= '0;
            end
        end else if (cur_we_i) begin
            i_q[cur_addr_i] <= cur_data_i;
        end
    end

    // Debug read samples the array before any same-edge commit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_u_q <= '0;
        end else begin
            rd_u_q <= u_q[rd_addr_i];
        end
    end

    assign rd_u_o        = rd_u_q;
    assign busy_o        = (state_q != ST_IDLE);
    assign step_done_o   = step_done_q;
    assign spk.spk_valid = spk_valid_q;
    assign spk.spk_id    = spk_id_q;

endmodule

// File: tb/tb_lif_array_sched.sv
// Self-checking bench for lif_array_sched: directed sweeps from a vector table,
// hand-written multi-cycle sequences, and randomized sweeps against a sweep-level model.
module tb_lif_array_sched;
    localparam int N   = 8;
    localparam int IDW = 3;
    localparam int THR = 239;
`ifdef LIF_SAT_EN
    localparam int U3_S3 = 255;
    localparam int REF_I = 240;
    localparam int REF_F = 2;
`else
    localparam int U3_S3 = 104;
    localparam int REF_I = 127;
    localparam int REF_F = 6;
`endif

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           en = 1'b1;
    logic           start = 1'b0;
    logic           cur_we = 1'b0;
    logic [IDW-1:0] cur_addr = '0;
    logic [7:0]     cur_data = '0;
    logic [IDW-1:0] rd_addr = '0;
    logic [7:0]     rd_u;
    logic           busy;
    logic           step_done;

    lif_array_sched_if #(.IDW(IDW)) spk_if ();

    lif_array_sched #(.N(N)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .en_i        (en),
        .start_i     (start),
        .cur_we_i    (cur_we),
        .cur_addr_i  (cur_addr),
        .cur_data_i  (cur_data),
        .rd_addr_i   (rd_addr),
        .rd_u_o      (rd_u),
        .busy_o      (busy),
        .step_done_o (step_done),
        .spk         (spk_if.master)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_bad = 0;
    int got_q[$];
    int busy_at_done;

    // Reference state: potentials, refractory timers, currents
    int m_u[N];
    int m_t[N];
    int m_i[N];

    typedef struct {
        int cur;
        int exp_spikes;
        int exp_u3;
        int exp_cycles;
    } vec_t;

    task automatic check(input string name, input int act, input int exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Record a handshake that the coming edge will perform, then advance.
    task automatic step(input logic rdy);
        spk_if.spk_ready = rdy;
        if (spk_if.spk_valid && rdy && en) got_q.push_back(int'(spk_if.spk_id));
        tick();
    endtask

    task automatic set_cur(input int a, input int d);
        cur_we   = 1'b1;
        cur_addr = IDW'(a);
        cur_data = 8'(d);
        tick();
        cur_we   = 1'b0;
        m_i[a]   = d;
    endtask

    task automatic read_u(input int a, output int v);
        rd_addr = IDW'(a);
        tick();
        v = int'(rd_u);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
        got_q.delete();
        for (int k = 0; k < N; k++) begin
            m_u[k] = 0;
            m_t[k] = 0;
            m_i[k] = 0;
        end
    endtask

    // Wait for step_done (bounded), then drain any pending event.
    task automatic finish_sweep(input int rmode, inout int cycles);
        while (!step_done && cycles < 200) begin
            step(rmode != 0 ? 1'($urandom_range(0, 1)) : 1'b1);
            cycles++;
        end
        if (!step_done) check("sweep_timeout", 0, 1);
        busy_at_done = int'(busy);
        for (int k = 0; k < 50 && spk_if.spk_valid; k++) step(1'b1);
        if (spk_if.spk_valid) check("drain_timeout", 1, 0);
    endtask

    task automatic run_sweep(input int rmode, output int cycles);
        start = 1'b1;
        step(1'b1);
        start = 1'b0;
        cycles = 1;
        finish_sweep(rmode, cycles);
    endtask

    function automatic int fold(input int v);
`ifdef LIF_SAT_EN
        return (v > 255) ? 255 : v;
`else
        return v % 256;
`endif
    endfunction

    // One timestep, neuron by neuron, as plain arithmetic.
    task automatic model_sweep(inout int exp_q[$]);
        for (int k = 0; k < N; k++) begin
            if (m_t[k] == 0 && m_u[k] >= THR) begin
                exp_q.push_back(k);
                m_u[k] = fold(m_u[k] + m_i[k] - THR);
                m_t[k] = 15;
            end else begin
                m_u[k] = fold(m_u[k] / 2 + m_i[k]);
                if (m_t[k] > 0) m_t[k] = m_t[k] - 1;
            end
        end
    endtask

    initial begin
        vec_t tbl[3];
        int cyc, v, nd, f;
        int fired[24];
        int exp_q[$];

        spk_if.spk_ready = 1'b1;
        tbl[0] = '{cur: 240, exp_spikes: 0, exp_u3: 240,   exp_cycles: N + 1};
        tbl[1] = '{cur: 240, exp_spikes: 1, exp_u3: 241,   exp_cycles: N + 1};
        tbl[2] = '{cur: 240, exp_spikes: 0, exp_u3: U3_S3, exp_cycles: N + 1};

        // Reset state
        tick(); tick();
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(step_done), 0);
        check("rst_valid", int'(spk_if.spk_valid), 0);
        check("rst_rd_u", int'(rd_u), 0);
        rst_n = 1'b1;
        do_reset();

        // Single spiker, table-driven
        for (int s = 0; s < 3; s++) begin
            set_cur(3, tbl[s].cur);
            got_q.delete();
            run_sweep(0, cyc);
            check($sformatf("tbl%0d_cycles", s), cyc, tbl[s].exp_cycles);
            check($sformatf("tbl%0d_busy_at_done", s), busy_at_done, 0);
            check($sformatf("tbl%0d_spikes", s), got_q.size(), tbl[s].exp_spikes);
            if (got_q.size() > 0) check($sformatf("tbl%0d_id", s), got_q[0], 3);
            read_u(3, v);
            check($sformatf("tbl%0d_u3", s), v, tbl[s].exp_u3);
        end

        // Async reset mid-sweep with a pending event at idx 4
        do_reset();
        set_cur(3, 240);
        run_sweep(0, cyc);
        rd_addr = 3;
        start = 1'b1;
        step(1'b0);
        start = 1'b0;
        for (int k = 0; k < 4; k++) step(1'b0);
        check("pre_rst_valid", int'(spk_if.spk_valid), 1);
        check("pre_rst_rd_u", int'(rd_u), 240);
        rst_n = 1'b0;
        #1;
        check("mid_rst_busy", int'(busy), 0);
        check("mid_rst_valid", int'(spk_if.spk_valid), 0);
        check("mid_rst_id", int'(spk_if.spk_id), 0);
        check("mid_rst_done", int'(step_done), 0);
        check("mid_rst_rd_u", int'(rd_u), 0);
        do_reset();
        set_cur(0, 5);
        run_sweep(0, cyc);
        check("post_rst_cycles", cyc, N + 1);
        read_u(0, v);
        check("post_rst_u0", v, 5);
        read_u(3, v);
        check("post_rst_u3", v, 0);

        // Backpressure: neuron 1 fires and is held, neuron 2 stalls for 4 cycles
        do_reset();
        set_cur(1, 240);
        set_cur(2, 240);
        run_sweep(0, cyc);
        rd_addr = 2;
        got_q.delete();
        start = 1'b1;
        step(1'b0);
        start = 1'b0;
        cyc = 1;
        for (int k = 0; k < 6; k++) begin step(1'b0); cyc++; end
        check("bp_valid", int'(spk_if.spk_valid), 1);
        check("bp_id", int'(spk_if.spk_id), 1);
        check("bp_busy", int'(busy), 1);
        check("bp_u2_held", int'(rd_u), 240);
        step(1'b1);
        cyc++;
        check("bp_next_valid", int'(spk_if.spk_valid), 1);
        check("bp_next_id", int'(spk_if.spk_id), 2);
        finish_sweep(0, cyc);
        check("bp_cycles", cyc, N + 1 + 4);
        check("bp_events", got_q.size(), 2);
        if (got_q.size() == 2) begin
            check("bp_ev0", got_q[0], 1);
            check("bp_ev1", got_q[1], 2);
        end

        // Refractory: one fire, silence for 15 sweeps, fire again on the 16th
        do_reset();
        set_cur(3, REF_I);
        for (int s = 1; s < 24; s++) begin
            got_q.delete();
            run_sweep(0, cyc);
            fired[s] = got_q.size();
        end
        f = 0;
        for (int s = 23; s >= 1; s--) if (fired[s] != 0) f = s;
        check("ref_first", f, REF_F);
        nd = 0;
        for (int s = f + 1; s <= f + 15 && s < 24; s++) nd += fired[s];
        check("ref_quiet", nd, 0);
        check("ref_refire", (f + 16 < 24) ? fired[f + 16] : -1, 1);

        // Start while busy is ignored
        do_reset();
        set_cur(4, 7);
        start = 1'b1;
        step(1'b1);
        start = 1'b0;
        cyc = 1;
        step(1'b1); step(1'b1); cyc += 2;
        start = 1'b1;
        step(1'b1);
        start = 1'b0;
        cyc++;
        finish_sweep(0, cyc);
        check("ctl_restart_cycles", cyc, N + 1);
        nd = 0;
        for (int k = 0; k < 12; k++) begin step(1'b1); nd += int'(step_done) + int'(busy); end
        check("ctl_no_restart", nd, 0);

        // en low for 3 cycles mid-sweep delays completion by exactly 3
        start = 1'b1;
        step(1'b1);
        start = 1'b0;
        cyc = 1;
        step(1'b1); step(1'b1); cyc += 2;
        en = 1'b0;
        for (int k = 0; k < 3; k++) begin step(1'b1); cyc++; end
        check("ctl_en_busy", int'(busy), 1);
        en = 1'b1;
        finish_sweep(0, cyc);
        check("ctl_en_cycles", cyc, N + 1 + 3);
        read_u(4, v);
        check("ctl_en_u4", v, 10);

        // Current write colliding with evaluation of neuron 5
        do_reset();
        set_cur(5, 10);
        rd_addr = 5;
        start = 1'b1;
        step(1'b1);
        start = 1'b0;
        cyc = 1;
        for (int k = 0; k < 5; k++) begin step(1'b1); cyc++; end
        cur_we   = 1'b1;
        cur_addr = 3'd5;
        cur_data = 8'd100;
        step(1'b1);
        cyc++;
        cur_we = 1'b0;
        check("col_rd_before", int'(rd_u), 0);
        step(1'b1);
        cyc++;
        check("col_rd_after", int'(rd_u), 10);
        finish_sweep(0, cyc);
        check("col_cycles", cyc, N + 1);
        run_sweep(0, cyc);
        read_u(5, v);
        check("col_next_sweep", v, 105);

        // Randomized currents and consumer readiness against the model
        do_reset();
        for (int s = 0; s < 10; s++) begin
            for (int k = 0; k < N; k++) begin
                if ($urandom_range(0, 2) == 0)
                    set_cur(k, ($urandom_range(0, 1) != 0) ? $urandom_range(0, 255)
                                                           : $urandom_range(200, 255));
            end
            exp_q.delete();
            model_sweep(exp_q);
            got_q.delete();
            run_sweep(1, cyc);
            check($sformatf("rnd%0d_nspk", s), got_q.size(), exp_q.size());
            for (int k = 0; k < exp_q.size() && k < got_q.size(); k++)
                check($sformatf("rnd%0d_id%0d", s, k), got_q[k], exp_q[k]);
            for (int k = 0; k < N; k++) begin
                read_u(k, v);
                check($sformatf("rnd%0d_u%0d", s, k), v, m_u[k]);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached, got %0d vectors expected completion", n_vec);
        $fatal(1, "watchdog");
    end

endmodule
